// File: rtl/sram_burst_ctrl_if.sv
// Command, write, read and SRAM bus bundle for sram_burst_ctrl.
// cmd_err exists only when SRAM_BURST_BOUNDS_CHK_EN is defined.
interface sram_burst_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 7
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              sram_en;
  logic              sram_rw;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
`ifdef SRAM_BURST_BOUNDS_CHK_EN
  logic              cmd_err;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, sram_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
           sram_en, sram_rw, sram_addr, sram_wdata, cmd_err
  );
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, sram_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
           sram_en, sram_rw, sram_addr, sram_wdata, cmd_err
  );
`else
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, sram_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
           sram_en, sram_rw, sram_addr, sram_wdata
  );
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, sram_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
           sram_en, sram_rw, sram_addr, sram_wdata
  );
`endif
endinterface

// File: rtl/sram_burst_ctrl.sv
// Burst controller in front of a synchronous single-port SRAM with a 2-entry read buffer.
// Optional bounds check (cmd_err) enabled by defining SRAM_BURST_BOUNDS_CHK_EN.
module sram_burst_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 7
) (
  input  logic               Clk,
  input  logic               Rst,
  sram_burst_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W:0]    remaining_q, remaining_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        occ_q, occ_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] buf_q [2];

  logic              cmd_ready, wr_ready, rd_valid;
  logic              cmd_fire, wr_fire, pop, push, issue;
  logic              sram_en, sram_rw;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;

  // Every handshake output is gated by Rst so a reset cycle never moves data.
  assign cmd_ready = (state_q == IDLE) & ~Rst;
  assign wr_ready  = (state_q == WRITE) & ~Rst;
  assign rd_valid  = (occ_q != 2'd0) & ~Rst;
  assign cmd_fire  = bus.cmd_valid & cmd_ready;
  assign wr_fire   = bus.wr_valid & wr_ready;
  assign pop       = rd_valid & bus.rd_ready;
  assign push      = inflight_q;
  // Only issue if the word can land in the buffer after this cycle's pop.
  assign issue     = ~Rst & (state_q == READ) & (remaining_q != '0) &
                     (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

`ifdef SRAM_BURST_BOUNDS_CHK_EN
  localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
  logic cmd_err_q, cmd_err_d;
  logic cmd_oob;
  assign cmd_oob     = (SUM_W'(bus.cmd_addr) + SUM_W'(bus.cmd_len)) > SUM_W'((1 << ADDR_W) - 1);
  assign bus.cmd_err = cmd_err_q & ~Rst;
`endif

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    inflight_d  = issue;
    done_d      = 1'b0;
`ifdef SRAM_BURST_BOUNDS_CHK_EN
    cmd_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
`ifdef SRAM_BURST_BOUNDS_CHK_EN
          if (cmd_oob) begin
            done_d    = 1'b1;
            cmd_err_d = 1'b1;
          end else begin
`endif
            cur_addr_d  = bus.cmd_addr;
            remaining_d = {1'b0, bus.cmd_len} + (LEN_W+1)'(1);
            state_d     = bus.cmd_write ? WRITE : READ;
`ifdef SRAM_BURST_BOUNDS_CHK_EN
          end
`endif
        end
      end
      WRITE: begin
        if (wr_fire) begin
          cur_addr_d  = cur_addr_q + ADDR_W'(1);
          remaining_d = remaining_q - (LEN_W+1)'(1);
          if (remaining_q == (LEN_W+1)'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          cur_addr_d  = cur_addr_q + ADDR_W'(1);
          remaining_d = remaining_q - (LEN_W+1)'(1);
          if (remaining_q == (LEN_W+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && occ_q == 2'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign occ_d = occ_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    sram_en    = 1'b0;
    sram_rw    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (state_q == WRITE && !Rst) begin
      sram_en    = bus.wr_valid;
      sram_rw    = bus.wr_valid;
      sram_addr  = cur_addr_q;
      sram_wdata = bus.wr_data;
    end else if (issue) begin
      sram_en   = 1'b1;
      sram_addr = cur_addr_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      done_q      <= 1'b0;
`ifdef SRAM_BURST_BOUNDS_CHK_EN
      cmd_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      done_q      <= done_d;
`ifdef SRAM_BURST_BOUNDS_CHK_EN
      cmd_err_q   <= cmd_err_d;
`endif
    end
  end

  // Buffer payload needs no reset; occupancy alone defines what is valid.
  always_ff @(posedge Clk) begin
    if (push) begin
      if (pop) begin
        if (occ_q == 2'd2) begin
          buf_q[0] <= buf_q[1];
          buf_q[1] <= bus.sram_rdata;
        end else begin
          buf_q[0] <= bus.sram_rdata;
        end
      end else if (occ_q == 2'd0) begin
        buf_q[0] <= bus.sram_rdata;
      end else begin
        buf_q[1] <= bus.sram_rdata;
      end
    end else if (pop) begin
      buf_q[0] <= buf_q[1];
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.wr_ready   = wr_ready;
  assign bus.rd_valid   = rd_valid;
  assign bus.rd_data    = rd_valid ? buf_q[0] : '0;
  assign bus.busy       = (state_q != IDLE) & ~Rst;
  assign bus.done       = done_q & ~Rst;
  assign bus.sram_en    = sram_en;
  assign bus.sram_rw    = sram_rw;
  assign bus.sram_addr  = sram_addr;
  assign bus.sram_wdata = sram_wdata;
endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Self-checking bench for sram_burst_ctrl: directed and random bursts against a golden memory model.
// Compile with SRAM_BURST_BOUNDS_CHK_EN to exercise the bounds-check build.
module tb_sram_burst_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_burst_ctrl_if #(.ADDR_W(7), .DATA_W(32), .LEN_W(7)) bus ();
  sram_burst_ctrl #(.ADDR_W(7), .DATA_W(32), .LEN_W(7)) dut (.Clk(clk), .Rst(rst), .bus(bus));

  // Behavioural SRAM: registered read, one-cycle latency.
  logic [31:0] mem [128] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_rw) mem[bus.sram_addr] <= bus.sram_wdata;
      else             bus.sram_rdata     <= mem[bus.sram_addr];
    end
  end

  int tests = 0, fails = 0;
  int done_cnt = 0, pop_cnt = 0, occ_m = 0;
  bit push_pend = 0;
  logic [31:0] gold [128];
  logic [38:0] exp_wr_q [$];
  logic [31:0] exp_rd_q [$];
  logic [31:0] wd [128];

  logic s_en, s_rw, s_rd_valid, s_pop, s_wr_ready, s_wr_fire, s_done, s_busy, s_cmd_ready, s_acc, s_err;
  logic [6:0]  s_addr;
  logic [31:0] s_wdata, s_rd_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle observer, called at the falling edge; events take effect at the next rising edge.
  task automatic sample();
    logic [38:0] ew;
    s_en = bus.sram_en;  s_rw = bus.sram_rw;  s_addr = bus.sram_addr;  s_wdata = bus.sram_wdata;
    s_rd_valid = bus.rd_valid;  s_rd_data = bus.rd_data;  s_wr_ready = bus.wr_ready;
    s_done = bus.done;  s_busy = bus.busy;  s_cmd_ready = bus.cmd_ready;
    s_pop = bus.rd_valid & bus.rd_ready;
    s_wr_fire = bus.wr_valid & bus.wr_ready;
    s_acc = bus.cmd_valid & bus.cmd_ready;
`ifdef SRAM_BURST_BOUNDS_CHK_EN
    s_err = bus.cmd_err;
`else
    s_err = 1'b0;
`endif
    if (s_en !== 1'b1) chk("rw_low_when_idle", s_rw, 0);
    if (s_wr_ready !== 1'b1) chk("wdata_zero_outside_write", s_wdata, 0);
    if (s_rd_valid !== 1'b1) chk("rd_data_zero_when_empty", s_rd_data, 0);
    chk("rd_valid_vs_occupancy", s_rd_valid, (occ_m != 0));
    if (push_pend) begin
      tests++;
      assert (occ_m < 2) else begin
        fails++;
        $error("FAIL push_into_full: observed occupancy %0d expected below 2", occ_m);
      end
    end
    if (s_en === 1'b1 && s_rw === 1'b1) begin
      if (exp_wr_q.size() == 0) chk("unexpected_sram_write", {25'd0, s_addr}, 32'hFFFF_FFFF);
      else begin
        ew = exp_wr_q.pop_front();
        chk("sram_write_addr", {25'd0, s_addr}, {25'd0, ew[38:32]});
        chk("sram_write_data", s_wdata, ew[31:0]);
      end
    end
    if (s_pop === 1'b1) begin
      if (exp_rd_q.size() == 0) chk("unexpected_read_word", s_rd_data, 32'hDEAD_BEEF);
      else chk("read_word", s_rd_data, exp_rd_q.pop_front());
      pop_cnt++;
    end
    if (s_done === 1'b1) done_cnt++;
    occ_m = occ_m + (push_pend ? 1 : 0) - ((s_pop === 1'b1) ? 1 : 0);
    push_pend = (s_en === 1'b1 && s_rw === 1'b0);
  endtask

  task automatic cyc();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input bit w, input logic [6:0] a, input logic [6:0] l);
    int k = 0;
    $display("[TB] %s burst addr=%0d len=%0d", w ? "write" : "read", a, l + 1);
    bus.cmd_valid = 1'b1;  bus.cmd_write = w;  bus.cmd_addr = a;  bus.cmd_len = l;
    s_acc = 1'b0;
    while (s_acc !== 1'b1 && k < 20) begin
      cyc();
      k++;
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_accept", s_acc, 1);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [6:0] l, input bit hold, input bit seq, input logic [31:0] base);
    int n = int'(l) + 1, beats = 0, cycles = 0, dc0;
    for (int i = 0; i < n; i++) begin
      logic [6:0] ad = a + 7'(i);
      wd[i] = seq ? base + 32'(i) : $urandom;
      gold[ad] = wd[i];
      exp_wr_q.push_back({ad, wd[i]});
    end
    bus.wr_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
    bus.wr_data  = wd[0];
    send_cmd(1'b1, a, l);
    dc0 = done_cnt;
    while (beats < n && cycles < 4 * n + 20) begin
      cyc();
      cycles++;
      if (s_wr_fire === 1'b1) beats++;
      if (beats < n) bus.wr_data = wd[beats];
      bus.wr_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
    end
    bus.wr_valid = 1'b0;
    chk("write_beats", beats, n);
    if (hold) chk("write_cycles_back_to_back", cycles, n);
    cyc();
    chk("write_done_next_cycle", s_done, 1);
    chk("write_done_count", done_cnt - dc0, 1);
    chk("write_queue_drained", exp_wr_q.size(), 0);
    chk("write_idle_cmd_ready", s_cmd_ready, 1);
  endtask

  // mode 0: rd_ready held, 1: pattern 1,0,0,1, 2: random
  task automatic do_read(input logic [6:0] a, input logic [6:0] l, input int mode);
    int n = int'(l) + 1, cycles = 0, first = -1, last_pop = -1, dc0, p0;
    bit seen_done = 0;
    for (int i = 0; i < n; i++) exp_rd_q.push_back(gold[a + 7'(i)]);
    send_cmd(1'b0, a, l);
    dc0 = done_cnt;
    p0 = pop_cnt;
    while (!seen_done && cycles < 2000) begin
      case (mode)
        0:       bus.rd_ready = 1'b1;
        1:       bus.rd_ready = ((cycles % 4) == 0) || ((cycles % 4) == 3);
        default: bus.rd_ready = 1'($urandom_range(0, 1));
      endcase
      cyc();
      cycles++;
      if (s_rd_valid === 1'b1 && first < 0) first = cycles;
      if (s_pop === 1'b1) last_pop = cycles;
      if (s_done === 1'b1) begin
        seen_done = 1;
        chk("read_done_after_all_words", exp_rd_q.size(), 0);
      end
    end
    chk("read_done_seen", seen_done, 1);
    chk("read_word_count", pop_cnt - p0, n);
    chk("read_done_count", done_cnt - dc0, 1);
    if (mode == 0) begin
      // Accept edge, then issue edge, then push edge: data visible in the third cycle.
      chk("read_first_latency", first, 3);
      chk("read_last_word_cycle", last_pop, n + 2);
    end
    cyc();
    chk("done_single_cycle", s_done, 0);
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    int pops, dc0;
    for (int i = 0; i < 128; i++) gold[i] = 32'h0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;  bus.cmd_write = 1'b0;  bus.cmd_addr = '0;  bus.cmd_len = '0;
    bus.wr_valid = 1'b0;   bus.wr_data = '0;      bus.rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("reset_sram_en", s_en, 0);
      chk("reset_busy", s_busy, 0);
      chk("reset_wr_ready", s_wr_ready, 0);
      chk("reset_rd_valid", s_rd_valid, 0);
    end
    rst = 1'b0;
    cyc();
    chk("post_reset_cmd_ready", s_cmd_ready, 1);
    chk("post_reset_busy", s_busy, 0);
    chk("post_reset_done", s_done, 0);
    chk("post_reset_sram_en", s_en, 0);

    do_write(7'd5, 7'd3, 1'b1, 1'b1, 32'hA0);
    do_read(7'd5, 7'd3, 0);

    do_write(7'd40, 7'd7, 1'b1, 1'b0, 32'h0);
    do_read(7'd40, 7'd7, 1);

`ifdef SRAM_BURST_BOUNDS_CHK_EN
    bus.wr_valid = 1'b1;
    dc0 = done_cnt;
    send_cmd(1'b1, 7'd120, 7'd10);
    cyc();
    chk("oob_cmd_err", s_err, 1);
    chk("oob_done", s_done, 1);
    chk("oob_no_sram", s_en, 0);
    chk("oob_no_wr_ready", s_wr_ready, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("oob_stay_idle", s_cmd_ready, 1);
      chk("oob_quiet_sram", s_en, 0);
      chk("oob_err_pulse", s_err, 0);
    end
    chk("oob_done_count", done_cnt - dc0, 1);
    bus.wr_valid = 1'b0;
`else
    do_write(7'd126, 7'd3, 1'b1, 1'b0, 32'h0);
    do_read(7'd126, 7'd3, 0);
    do_write(7'd64, 7'd127, 1'b0, 1'b0, 32'h0);
    do_read(7'd64, 7'd127, 2);
`endif

    for (int t = 0; t < 12; t++) begin
      logic [6:0] a = 7'($urandom_range(0, 127));
      logic [6:0] l = 7'($urandom_range(0, 31));
`ifdef SRAM_BURST_BOUNDS_CHK_EN
      if (int'(a) + int'(l) > 127) l = 7'd127 - a;
`endif
      if ($urandom_range(0, 1) == 1) do_write(a, l, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
      else                            do_read(a, l, int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a read burst after two words.
    for (int i = 0; i < 8; i++) exp_rd_q.push_back(gold[7'd10 + 7'(i)]);
    send_cmd(1'b0, 7'd10, 7'd7);
    bus.rd_ready = 1'b1;
    pops = 0;
    for (int k = 0; k < 20 && pops < 2; k++) begin
      cyc();
      if (s_pop === 1'b1) pops++;
    end
    chk("pre_reset_words", pops, 2);
    rst = 1'b1;
    exp_rd_q.delete();
    occ_m = 0;
    push_pend = 0;
    dc0 = done_cnt;
    cyc();
    chk("midrst_rd_valid", s_rd_valid, 0);
    chk("midrst_sram_en", s_en, 0);
    chk("midrst_busy", s_busy, 0);
    chk("midrst_done", s_done, 0);
    rst = 1'b0;
    cyc();
    chk("midrst_cmd_ready_after", s_cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("midrst_no_access", s_en, 0);
      chk("midrst_no_data", s_rd_valid, 0);
    end
    chk("midrst_no_done", done_cnt - dc0, 0);
    bus.rd_ready = 1'b0;

    // Buffer state after reset must not leak into the next burst.
    do_write(7'd10, 7'd2, 1'b1, 1'b1, 32'h55);
    do_read(7'd10, 7'd2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
